mdu_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit with architectural HI/LO registers, beside the ALU in EX.

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_iter_core.sv | 64 ++++++
 rtl/mdu_iter.sv | 141 ++++++++++++++
 tb/tb_mdu_iter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states and small op-classification helpers.
package mdu_pkg;

   typedef enum logic [3:0] {
      MDU_MULT  = 4'd0,
      MDU_MULTU = 4'd1,
      MDU_DIV   = 4'd2,
      MDU_DIVU  = 4'd3,
      MDU_MADD  = 4'd4,
      MDU_MADDU = 4'd5,
      MDU_MSUB  = 4'd6,
      MDU_MSUBU = 4'd7,
      MDU_MTHI  = 4'd8,
      MDU_MTLO  = 4'd9
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

   function automatic logic op_is_signed(input logic [3:0] o);
      return (o == MDU_MULT) || (o == MDU_DIV) || (o == MDU_MADD) || (o == MDU_MSUB);
   endfunction

   function automatic logic op_is_div(input logic [3:0] o);
      return (o == MDU_DIV) || (o == MDU_DIVU);
   endfunction

   function automatic logic op_is_move(input logic [3:0] o);
      return (o == MDU_MTHI) || (o == MDU_MTLO);
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply or restoring divide,
// one bit per step, WIDTH steps per operation.
module mdu_iter_core
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic                 div_mode,
   input  logic [WIDTH-1:0]     a_mag,
   input  logic [WIDTH-1:0]     b_mag,
   output logic [2*WIDTH-1:0]   result,
   output logic                 last_cycle
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0]    count;
   logic             mode_div;
   logic [WIDTH-1:0] upper;
   logic [WIDTH-1:0] lower;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   shifted;
   logic             fits;

   // Multiply: upper accumulates the partial product, lower holds the multiplier
   // and collects product bits. Divide: upper is the remainder, lower shifts the
   // dividend out and the quotient in.
   assign add_sum    = {1'b0, upper} + (lower[0] ? {1'b0, divisor} : '0);
   assign shifted    = {upper, lower[WIDTH-1]};
   assign fits       = (shifted >= {1'b0, divisor});
   assign result     = {upper, lower};
   assign last_cycle = (count == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         mode_div <= 1'b0;
         upper    <= '0;
         lower    <= '0;
         divisor  <= '0;
      end else if (load) begin
         count    <= '0;
         mode_div <= div_mode;
         upper    <= '0;
         lower    <= a_mag;
         divisor  <= b_mag;
      end else if (step) begin
         count <= last_cycle ? '0 : count + 1'b1;
         if (mode_div) begin
            upper <= fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
            lower <= {lower[WIDTH-2:0], fits};
         end else begin
            upper <= add_sum[WIDTH:1];
            lower <= {add_sum[0], lower[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers: FSM, sign handling,
// multiply-accumulate and the architectural result registers.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int EN_MACC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_t state, state_nxt;

   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [WIDTH-1:0]   hi_nxt, lo_nxt, fix_hi, fix_lo;
   logic               done_nxt, load, last_cycle;
   logic               in_signed, a_neg_in, b_neg_in;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] raw, prod, acc;
   logic [WIDTH-1:0]   quot, rem;
   logic               a_neg, b_neg, res_neg;

   assign ready = (state == IDLE);
   assign busy  = ~ready;

   // Signed operands go to the core as magnitudes; MIN_INT maps to 2^(WIDTH-1).
   assign in_signed = op_is_signed(op);
   assign a_neg_in  = in_signed & src_a[WIDTH-1];
   assign b_neg_in  = in_signed & src_b[WIDTH-1];
   assign a_mag     = a_neg_in ? (~src_a + 1'b1) : src_a;
   assign b_mag     = b_neg_in ? (~src_b + 1'b1) : src_b;

   mdu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .step       (state == CALC),
      .div_mode   (op_is_div(op)),
      .a_mag      (a_mag),
      .b_mag      (b_mag),
      .result     (raw),
      .last_cycle (last_cycle)
   );

   assign a_neg   = op_is_signed(op_q) & a_q[WIDTH-1];
   assign b_neg   = op_is_signed(op_q) & b_q[WIDTH-1];
   assign res_neg = a_neg ^ b_neg;
   assign prod    = res_neg ? (~raw + 1'b1) : raw;
   assign acc     = {hi, lo};
   assign quot    = raw[WIDTH-1:0];
   assign rem     = raw[2*WIDTH-1:WIDTH];

   // Result selection for the FIX cycle; MACC uses hi/lo as they stand now.
   always_comb begin
      fix_hi = hi;
      fix_lo = lo;
      case (op_q)
         MDU_MULT, MDU_MULTU: {fix_hi, fix_lo} = prod;
         MDU_MADD, MDU_MADDU: if (EN_MACC != 0) {fix_hi, fix_lo} = acc + prod;
         MDU_MSUB, MDU_MSUBU: if (EN_MACC != 0) {fix_hi, fix_lo} = acc - prod;
         MDU_DIV, MDU_DIVU: begin
            if (b_q == '0) begin
               fix_lo = '1;
               fix_hi = a_q;
            end else begin
               fix_lo = res_neg ? (~quot + 1'b1) : quot;
               fix_hi = a_neg ? (~rem + 1'b1) : rem;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      hi_nxt    = hi;
      lo_nxt    = lo;
      done_nxt  = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (op == MDU_MTHI)      hi_nxt = src_a;
               else if (op == MDU_MTLO) lo_nxt = src_a;
               else begin
                  load      = 1'b1;
                  state_nxt = CALC;
               end
            end
         end
         CALC: begin
            if (flush)           state_nxt = IDLE;
            else if (last_cycle) state_nxt = FIX;
         end
         FIX: begin
            state_nxt = IDLE;
            if (!flush) begin
               done_nxt = 1'b1;
               hi_nxt   = fix_hi;
               lo_nxt   = fix_lo;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         state <= state_nxt;
         hi    <= hi_nxt;
         lo    <= lo_nxt;
         done  <= done_nxt;
         if (load) begin
            op_q <= op;
            a_q  <= src_a;
            b_q  <= src_b;
         end
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter (WIDTH=32) with a small expected-result
// queue, latency checks, flush, reset and handshake cases.
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        flush = 1'b0;
   logic        ready, busy, done;
   logic [31:0] hi, lo;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] cur_hi = '0;
   logic [31:0] cur_lo = '0;
   logic [63:0] exp_q[$];
   int          lat;
   int          dones;

   localparam logic [3:0] OP_MULT = 4'd0, OP_MULTU = 4'd1, OP_DIV = 4'd2, OP_DIVU = 4'd3;
   localparam logic [3:0] OP_MADDU = 4'd5, OP_MSUB = 4'd6, OP_MTHI = 4'd8, OP_MTLO = 4'd9;

   mdu_iter #(.WIDTH(32), .EN_MACC(1)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .flush (flush),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; presents a request for one edge, then scrambles the
   // operand inputs so late changes would corrupt a result that failed to latch them.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 4'd0;
      src_a = $urandom;
      src_b = $urandom;
   endtask

   // Counts edges from the accepting edge (which counts as 1) until done is seen.
   task automatic wait_done(input int from, output int cyc);
      cyc = from;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cyc++;
         if (done) return;
      end
      cyc = -1;
   endtask

   task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      logic [63:0] e;
      int c;
      exp_q.push_back({eh, el});
      issue(o, a, b);
      wait_done(0, c);
      check({tag, " latency"}, 64'(c), 64'd34);
      e = exp_q.pop_front();
      check({tag, " hi_lo"}, {hi, lo}, e);
      {cur_hi, cur_lo} = e;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset ready", 64'(ready), 64'd1);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset hi_lo", {hi, lo}, 64'd0);

      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      @(negedge clk);
      check("done one cycle", 64'(done), 64'd0);
      run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE);
      run_op("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_7_neg2", OP_DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
      run_op("div_minint", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_op("divu_zero", OP_DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF);
      run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

      // MTHI/MTLO: immediate write, no done pulse
      @(negedge clk);
      issue(OP_MTHI, 32'h0, 32'h0);
      @(negedge clk);
      check("mthi hi", 64'(hi), 64'h0);
      issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
      @(negedge clk);
      check("mtlo lo", 64'(lo), 64'hFFFF_FFFF);
      check("mtlo no done", 64'(done), 64'd0);
      check("mtlo ready", 64'(ready), 64'd1);
      run_op("maddu", OP_MADDU, 32'h1, 32'h1, 32'h1, 32'h0);
      run_op("msub", OP_MSUB, 32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF);

      // Flush at CALC counter 5, with a simultaneous start that must be dropped
      @(negedge clk);
      issue(OP_DIV, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      start = 1'b1;
      op    = OP_DIVU;
      @(negedge clk);
      check("flush ready", 64'(ready), 64'd1);
      check("flush no done", 64'(done), 64'd0);
      flush = 1'b0;
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      check("flush idle after", 64'(dones), 64'd0);
      check("flush hi_lo", {hi, lo}, {cur_hi, cur_lo});

      // start while busy is ignored; then back-to-back start in the done cycle
      exp_q.push_back({32'd2, 32'd14});
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      check("busy mid op", 64'(busy), 64'd1);
      start = 1'b1;
      op    = OP_MTLO;
      src_a = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      wait_done(4, lat);
      check("busy start latency", 64'(lat), 64'd34);
      check("busy start hi_lo", {hi, lo}, exp_q.pop_front());
      {cur_hi, cur_lo} = {32'd2, 32'd14};
      run_op("b2b multu", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0);

      // Undefined op: completes with done, hi/lo unchanged
      @(negedge clk);
      issue(4'hC, 32'h5, 32'h5);
      wait_done(0, lat);
      check("undef done", 64'(lat > 0), 64'd1);
      check("undef hi_lo", {hi, lo}, {cur_hi, cur_lo});

      // Flush in IDLE does not block MTHI
      @(negedge clk);
      flush = 1'b1;
      issue(OP_MTHI, 32'h0000_ABCD, 32'h0);
      flush = 1'b0;
      @(negedge clk);
      check("idle flush mthi", 64'(hi), 64'h0000_ABCD);

      // Reset in the middle of an op
      issue(OP_MULT, 32'h3, 32'h5);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst ready", 64'(ready), 64'd1);
      check("midrst hi_lo", {hi, lo}, 64'd0);
      check("midrst done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op("post rst multu", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
